// File: rtl/rebble_display_host.sv
// SPI master feeding one frame (command byte, then ROWS*COLS pixel bytes) to the rebble display panel.
// Waits for the panel's intn acknowledge, and aborts cleanly if reset_done drops mid-frame.
module rebble_display_host #(
  parameter int          SCK_HALF    = 2,
  parameter int          CS_SETUP    = 8,
  parameter int          ROWS        = 168,
  parameter int          COLS        = 144,
  parameter logic [7:0]  CMD_FRAME   = 8'h05,
  parameter int          ACK_TIMEOUT = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  input  logic [7:0] i_pix_data,
  input  logic       i_pix_valid,
  output logic       o_pix_ready,
  output logic [7:0] o_row,
  output logic [7:0] o_col,
  output logic       o_cs,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso,
  input  logic       i_reset_done,
  input  logic       i_intn
);

  localparam int MAX_A   = (CS_SETUP > SCK_HALF) ? CS_SETUP : SCK_HALF;
  localparam int CNT_MAX = (ACK_TIMEOUT > MAX_A) ? ACK_TIMEOUT : MAX_A;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCK_HALF - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

  typedef enum logic [3:0] {
    IDLE, CMD_SETUP, CMD_SHIFT, GAP, PIX_SETUP, PIX_WAIT, PIX_SHIFT, FINISH, ACK_WAIT
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit, w_bit_next, w_bit_inc;
  logic [7:0]       r_shift, w_shift_next;
  logic [ROW_W-1:0] r_row, w_row_next;
  logic [COL_W-1:0] r_col, w_col_next;
  logic             r_cs, w_cs_next;
  logic             r_sck, w_sck_next;
  logic             r_mosi, w_mosi_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_ack_err, w_ack_err_next;
  logic             r_intn_s1, r_intn_s2;
  logic             w_setup_end, w_half_end, w_ack_end, w_last_pix;
  logic             w_unused_miso;

  assign w_unused_miso = i_miso;
  assign w_bit_inc     = r_bit + 3'd1;
  assign w_setup_end   = (r_cnt == SETUP_LAST);
  assign w_half_end    = (r_cnt == HALF_LAST);
  assign w_ack_end     = (r_cnt == ACK_LAST);
  assign w_last_pix    = (r_row == ROW_LAST) && (r_col == COL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_intn_s1 <= 1'b1;
      r_intn_s2 <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit     <= w_bit_next;
      r_shift   <= w_shift_next;
      r_row     <= w_row_next;
      r_col     <= w_col_next;
      r_cs      <= w_cs_next;
      r_sck     <= w_sck_next;
      r_mosi    <= w_mosi_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_ack_err <= w_ack_err_next;
      r_intn_s1 <= i_intn;
      r_intn_s2 <= r_intn_s1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_next     = r_bit;
    w_shift_next   = r_shift;
    w_row_next     = r_row;
    w_col_next     = r_col;
    w_cs_next      = r_cs;
    w_sck_next     = r_sck;
    w_mosi_next    = r_mosi;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_ack_err_next = r_ack_err;

    case (r_state)
      IDLE: begin
        if (i_start && i_reset_done) begin
          w_state_next   = CMD_SETUP;
          w_busy_next    = 1'b1;
          w_cs_next      = 1'b0;
          w_cnt_next     = '0;
          w_ack_err_next = 1'b0;
          w_row_next     = '0;
          w_col_next     = '0;
        end
      end
      CMD_SETUP, GAP, PIX_SETUP: begin
        if (!w_setup_end) begin
          w_cnt_next = r_cnt + CNT_ONE;
        end else begin
          w_cnt_next = '0;
          if (r_state == CMD_SETUP) begin
            w_state_next = CMD_SHIFT;
            w_shift_next = CMD_FRAME;
            w_mosi_next  = CMD_FRAME[0];
            w_bit_next   = '0;
          end else if (r_state == GAP) begin
            w_state_next = PIX_SETUP;
            w_cs_next    = 1'b0;
          end else begin
            w_state_next = PIX_WAIT;
          end
        end
      end
      CMD_SHIFT, PIX_SHIFT: begin
        if (!w_half_end) begin
          w_cnt_next = r_cnt + CNT_ONE;
        end else begin
          w_cnt_next = '0;
          if (!r_sck) begin
            w_sck_next = 1'b1;
          end else begin
            // falling sck edge: next bit goes out while sck is low
            w_sck_next = 1'b0;
            if (r_bit != 3'd7) begin
              w_bit_next  = w_bit_inc;
              w_mosi_next = r_shift[w_bit_inc];
            end else begin
              w_mosi_next = 1'b0;
              if (r_state == CMD_SHIFT) begin
                w_cs_next    = 1'b1;
                w_state_next = GAP;
              end else if (w_last_pix) begin
                w_state_next = FINISH;
              end else begin
                w_state_next = PIX_WAIT;
                if (r_col == COL_LAST) begin
                  w_col_next = '0;
                  w_row_next = r_row + ROW_ONE;
                end else begin
                  w_col_next = r_col + COL_ONE;
                end
              end
            end
          end
        end
      end
      PIX_WAIT: begin
        if (i_pix_valid) begin
          w_state_next = PIX_SHIFT;
          w_shift_next = i_pix_data;
          w_mosi_next  = i_pix_data[0];
          w_bit_next   = '0;
          w_cnt_next   = '0;
        end
      end
      FINISH: begin
        if (w_half_end) begin
          w_cnt_next   = '0;
          w_cs_next    = 1'b1;
          w_state_next = ACK_WAIT;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ACK_WAIT: begin
        if (!r_intn_s2 || w_ack_end) begin
          w_ack_err_next = r_ack_err | r_intn_s2;
          w_done_next    = 1'b1;
          w_busy_next    = 1'b0;
          w_row_next     = '0;
          w_col_next     = '0;
          w_cnt_next     = '0;
          w_state_next   = IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // panel lost readiness: drop the bus immediately, no partial byte finishes
    if ((r_state != IDLE) && !i_reset_done) begin
      w_state_next   = IDLE;
      w_cs_next      = 1'b1;
      w_sck_next     = 1'b0;
      w_mosi_next    = 1'b0;
      w_busy_next    = 1'b0;
      w_done_next    = 1'b1;
      w_ack_err_next = 1'b1;
      w_cnt_next     = '0;
      w_row_next     = '0;
      w_col_next     = '0;
    end
  end

  assign o_pix_ready = (r_state == PIX_WAIT) && i_pix_valid && i_reset_done;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ack_err   = r_ack_err;
  assign o_row       = 8'(r_row);
  assign o_col       = 8'(r_col);
  assign o_cs        = r_cs;
  assign o_sck       = r_sck;
  assign o_mosi      = r_mosi;

endmodule

// File: tb/tb_rebble_display_host.sv
// Directed bench for rebble_display_host on a reduced 8x16 frame with an SPI slave model
// that rebuilds every byte seen on the bus.
`timescale 1ns/1ps
module tb_rebble_display_host;

  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int NPIX  = ROWS * COLS;
  localparam int LIMIT = 12000;
  localparam int LOGSZ = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_valid = 1'b0;
  logic       miso = 1'b0;
  logic       reset_done = 1'b0;
  logic       intn = 1'b1;
  logic       o_busy, o_done, o_ack_err, o_pix_ready, o_cs, o_sck, o_mosi;
  logic [7:0] o_row, o_col;

  int err_cnt = 0;
  int chk_cnt = 0;

  rebble_display_host #(
    .SCK_HALF(2), .CS_SETUP(8), .ROWS(ROWS), .COLS(COLS),
    .CMD_FRAME(8'h05), .ACK_TIMEOUT(100)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(o_busy), .o_done(o_done), .o_ack_err(o_ack_err),
    .i_pix_data(pix_data), .i_pix_valid(pix_valid), .o_pix_ready(o_pix_ready),
    .o_row(o_row), .o_col(o_col),
    .o_cs(o_cs), .o_sck(o_sck), .o_mosi(o_mosi),
    .i_miso(miso), .i_reset_done(reset_done), .i_intn(intn)
  );

  always #5 clk = ~clk;

  // SPI slave model (mode 0, LSB first)
  int         win_cnt = 0;
  int         sck_rises = 0;
  int         byte_total = 0;
  int         nb = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] byte_log [LOGSZ];
  int         byte_win [LOGSZ];

  always @(negedge o_cs or posedge o_sck) begin
    if (o_sck === 1'b1 && o_cs === 1'b0) begin
      sh = {o_mosi, sh[7:1]};
      sck_rises++;
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (byte_total < LOGSZ) begin
          byte_log[byte_total] = sh;
          byte_win[byte_total] = win_cnt;
        end
        byte_total++;
      end
    end else if (o_cs === 1'b0) begin
      win_cnt++;
      nb = 0;
    end
  end

  int ready_cnt = 0;
  always @(posedge clk) if (o_pix_ready && pix_valid) ready_cnt++;

  // per-frame observations
  int fr_ready_base, fr_byte_base, fr_win_base, fr_rise_base;
  int done_cnt, done_cyc, cs_rise_cyc, stall_bad;
  bit stall_seen, timed_out, cs_after_abort, sck_after_abort, err_after_start;

  function automatic logic [7:0] pat(input int k, input bit col_pat);
    int v;
    v = col_pat ? (k % COLS) : ((k * 7 + 3) % 256);
    return 8'(v);
  endfunction

  // counts bytes per window of the last frame and pixel bytes that differ from the pattern
  task automatic scan_image(input bit col_pat, output int ncmd, output logic [7:0] cmdb,
                            output int npix, output int mism);
    ncmd = 0; cmdb = 8'h00; npix = 0; mism = 0;
    for (int i = fr_byte_base; i < byte_total && i < LOGSZ; i++) begin
      if (byte_win[i] == fr_win_base + 1) begin
        ncmd++;
        cmdb = byte_log[i];
      end else if (byte_win[i] == fr_win_base + 2) begin
        if (byte_log[i] !== pat(npix, col_pat)) mism++;
        npix++;
      end
    end
  endtask

  task automatic drive_frame(input int stall_k, input int stall_len, input bit col_pat,
                             input int abort_k, input bit give_ack);
    int k, cyc, stall_left, rises_seen;
    bit prev_cs, stalling, stall_done, aborted, abort_obs;
    fr_ready_base = ready_cnt; fr_byte_base = byte_total;
    fr_win_base = win_cnt;     fr_rise_base = sck_rises;
    done_cnt = 0; done_cyc = -1; cs_rise_cyc = -1; stall_bad = 0;
    stall_seen = 0; timed_out = 0; cs_after_abort = 0; sck_after_abort = 1;
    k = 0; stall_left = 0; rises_seen = 0; prev_cs = 1'b1;
    stalling = 0; stall_done = 0; aborted = 0; abort_obs = 0;
    @(negedge clk); start = 1'b1; pix_valid = 1'b1; pix_data = pat(0, col_pat);
    @(negedge clk); start = 1'b0; err_after_start = o_ack_err;
    cyc = 0;
    while (1) begin
      if (o_done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (o_cs && !prev_cs) begin rises_seen++; cs_rise_cyc = cyc; end
      prev_cs = o_cs;
      if (aborted && !abort_obs) begin
        cs_after_abort = o_cs; sck_after_abort = o_sck; abort_obs = 1;
      end
      if (stalling && (o_cs !== 1'b0 || o_sck !== 1'b0)) stall_bad++;
      if (!stalling && !stall_done && k == stall_k &&
          o_row == 8'(stall_k / COLS) && o_col == 8'(stall_k % COLS)) begin
        stalling = 1; stall_left = stall_len; stall_seen = 1;
      end
      if (stalling) begin
        if (stall_left == 0) begin stalling = 0; stall_done = 1; end
        else stall_left--;
      end
      pix_valid = !stalling;
      pix_data  = pat(k, col_pat);
      if (!aborted && abort_k >= 0 && k == abort_k) begin reset_done = 1'b0; aborted = 1; end
      if (give_ack && rises_seen >= 2) intn = 1'b0;
      #1;
      if (o_pix_ready) k++;
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      if (cyc >= LIMIT) begin timed_out = 1; break; end
      cyc++;
      @(negedge clk);
    end
    intn = 1'b1; pix_valid = 1'b0; reset_done = 1'b1;
    $display("frame: ready=%0d bytes=%0d done_cnt=%0d done_cyc=%0d cs_rise_cyc=%0d ack_err=%0b",
             ready_cnt - fr_ready_base, byte_total - fr_byte_base, done_cnt, done_cyc,
             cs_rise_cyc, o_ack_err);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; reset_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (o_cs !== 1'b1) begin err_cnt++; $display("FAIL reset_cs: got %0b want 1", o_cs); end
    chk_cnt++; if (o_sck !== 1'b0) begin err_cnt++; $display("FAIL reset_sck: got %0b want 0", o_sck); end
    chk_cnt++; if (o_mosi !== 1'b0) begin err_cnt++; $display("FAIL reset_mosi: got %0b want 0", o_mosi); end
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_ack_err !== 1'b0)
      begin err_cnt++; $display("FAIL reset_flags: busy/done/err got %0b%0b%0b want 000", o_busy, o_done, o_ack_err); end
    chk_cnt++; if (o_pix_ready !== 1'b0 || o_row !== 8'd0 || o_col !== 8'd0)
      begin err_cnt++; $display("FAIL reset_pix: ready=%0b row=%0d col=%0d want 0/0/0", o_pix_ready, o_row, o_col); end
    $display("reset: cs=%0b sck=%0b busy=%0b", o_cs, o_sck, o_busy);
  endtask

  task automatic test_start_gated;
    int bad;
    reset_done = 1'b0; bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) begin @(negedge clk); if (o_cs !== 1'b1 || o_busy !== 1'b0) bad++; end
    chk_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL gated_start: %0d active cycles, want 0", bad); end
    reset_done = 1'b1;
    repeat (5) @(negedge clk);
    chk_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL gated_latch: busy=%0b want 0", o_busy); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_cnt++; if (o_busy !== 1'b1 || o_cs !== 1'b0)
      begin err_cnt++; $display("FAIL start_accept: busy=%0b cs=%0b want 1/0", o_busy, o_cs); end
    $display("start gating: busy=%0b cs=%0b", o_busy, o_cs);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_full_frame;
    int ncmd, npix, mism;
    logic [7:0] cmdb;
    drive_frame(-1, 0, 1'b0, -1, 1'b1);
    scan_image(1'b0, ncmd, cmdb, npix, mism);
    chk_cnt++; if (timed_out) begin err_cnt++; $display("FAIL full_timeout: frame did not finish in %0d cycles", LIMIT); end
    chk_cnt++; if (ncmd != 1 || cmdb !== 8'h05)
      begin err_cnt++; $display("FAIL full_cmd: %0d bytes, last %h want 1 byte 05", ncmd, cmdb); end
    chk_cnt++; if (ready_cnt - fr_ready_base != NPIX)
      begin err_cnt++; $display("FAIL full_ready: got %0d want %0d", ready_cnt - fr_ready_base, NPIX); end
    chk_cnt++; if (npix != NPIX || mism != 0)
      begin err_cnt++; $display("FAIL full_image: bytes=%0d bad=%0d want %0d/0", npix, mism, NPIX); end
    chk_cnt++; if (sck_rises - fr_rise_base != 8 * (NPIX + 1))
      begin err_cnt++; $display("FAIL full_sck: got %0d want %0d", sck_rises - fr_rise_base, 8 * (NPIX + 1)); end
    chk_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL full_done: got %0d want 1", done_cnt); end
    chk_cnt++; if (o_ack_err !== 1'b0 || o_busy !== 1'b0 || o_row !== 8'd0 || o_col !== 8'd0)
      begin err_cnt++; $display("FAIL full_end: err=%0b busy=%0b row=%0d col=%0d want 0", o_ack_err, o_busy, o_row, o_col); end
  endtask

  task automatic test_stall_image;
    int ncmd, npix, mism;
    logic [7:0] cmdb;
    drive_frame(5 * COLS + 10, 37, 1'b1, -1, 1'b1);
    scan_image(1'b1, ncmd, cmdb, npix, mism);
    chk_cnt++; if (!stall_seen) begin err_cnt++; $display("FAIL stall_reach: got 0 want 1 (row 5 col 10 never waited)"); end
    chk_cnt++; if (stall_bad != 0) begin err_cnt++; $display("FAIL stall_bus: %0d bad cycles want 0", stall_bad); end
    chk_cnt++; if (npix != NPIX || mism != 0)
      begin err_cnt++; $display("FAIL stall_image: bytes=%0d bad=%0d want %0d/0", npix, mism, NPIX); end
    chk_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_ack_timeout;
    int bad;
    drive_frame(-1, 0, 1'b0, -1, 1'b0);
    chk_cnt++; if (done_cyc - cs_rise_cyc != 100)
      begin err_cnt++; $display("FAIL ack_timeout_delay: got %0d want 100", done_cyc - cs_rise_cyc); end
    chk_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL ack_timeout_done: got %0d want 1", done_cnt); end
    bad = 0;
    repeat (20) begin @(negedge clk); if (o_ack_err !== 1'b1) bad++; end
    chk_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL ack_err_sticky: %0d cycles low want 0", bad); end
  endtask

  task automatic test_err_clear;
    drive_frame(-1, 0, 1'b0, -1, 1'b1);
    chk_cnt++; if (err_after_start !== 1'b0)
      begin err_cnt++; $display("FAIL err_clear: got %0b want 0 after start", err_after_start); end
    chk_cnt++; if (o_ack_err !== 1'b0 || done_cnt != 1)
      begin err_cnt++; $display("FAIL err_clear_end: err=%0b done=%0d want 0/1", o_ack_err, done_cnt); end
  endtask

  task automatic test_abort;
    int ncmd, npix, mism, rdy;
    logic [7:0] cmdb;
    drive_frame(-1, 0, 1'b0, 50, 1'b0);
    scan_image(1'b0, ncmd, cmdb, npix, mism);
    rdy = ready_cnt - fr_ready_base;
    chk_cnt++; if (cs_after_abort !== 1'b1 || sck_after_abort !== 1'b0)
      begin err_cnt++; $display("FAIL abort_bus: cs=%0b sck=%0b want 1/0", cs_after_abort, sck_after_abort); end
    chk_cnt++; if (rdy != 50 && rdy != 51) begin err_cnt++; $display("FAIL abort_ready: got %0d want 50 or 51", rdy); end
    chk_cnt++; if (npix >= rdy || mism != 0)
      begin err_cnt++; $display("FAIL abort_partial: bytes=%0d bad=%0d want <%0d/0", npix, mism, rdy); end
    chk_cnt++; if (done_cnt != 1 || o_ack_err !== 1'b1 || o_busy !== 1'b0)
      begin err_cnt++; $display("FAIL abort_flags: done=%0d err=%0b busy=%0b want 1/1/0", done_cnt, o_ack_err, o_busy); end
  endtask

  task automatic test_async_reset;
    int bad, rises0, w0, wb, rb, cyc;
    bit hit;
    wb = win_cnt; rb = ready_cnt; hit = 0;
    reset_done = 1'b1; pix_valid = 1'b1; pix_data = 8'hA5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (win_cnt == wb + 2 && o_sck === 1'b1 && ready_cnt - rb >= 3) begin hit = 1; break; end
    end
    chk_cnt++; if (!hit) begin err_cnt++; $display("FAIL areset_reach: got 0 want 1 (no pixel shift seen)"); end
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (o_cs !== 1'b1 || o_sck !== 1'b0 || o_busy !== 1'b0 || o_mosi !== 1'b0)
      begin err_cnt++; $display("FAIL areset_now: cs=%0b sck=%0b busy=%0b mosi=%0b want 1/0/0/0", o_cs, o_sck, o_busy, o_mosi); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rises0 = sck_rises; w0 = win_cnt; bad = 0;
    repeat (50) begin @(negedge clk); if (o_cs !== 1'b1 || o_busy !== 1'b0 || o_pix_ready !== 1'b0) bad++; end
    chk_cnt++; if (bad != 0 || sck_rises != rises0 || win_cnt != w0)
      begin err_cnt++; $display("FAIL areset_quiet: bad=%0d rises=%0d windows=%0d want 0/0/0", bad, sck_rises - rises0, win_cnt - w0); end
    pix_valid = 1'b0;
    $display("async reset: cs=%0b busy=%0b", o_cs, o_busy);
  endtask

  initial begin
    test_reset();
    test_start_gated();
    test_full_frame();
    test_stall_image();
    test_ack_timeout();
    test_err_clear();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
